// File: rtl/scroll_displayer_pkg.sv
// scroll_displayer shared types and constants.
// Mode and direction encodings, blank pattern, hex decoder.
package scroll_displayer_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order g..a
  function automatic logic [6:0] hex2seg(
    input logic [3:0] h
  );
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scroll_displayer_if.sv
// scroll_displayer control/display bundle.
// master drives controls and message, slave drives display.
interface scroll_displayer_if #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 16,
  parameter int LED_W      = 8
) ();

  logic                    en;
  logic [1:0]              mode;
  logic [MSG_LEN*4-1:0]    msg;
  logic [NUM_DIGITS*7-1:0] digits;
  logic [LED_W-1:0]        led;
  logic                    step;

  modport master (
    output en,
    output mode,
    output msg,
    input  digits,
    input  led,
    input  step
  );

  modport slave (
    input  en,
    input  mode,
    input  msg,
    output digits,
    output led,
    output step
  );

endinterface

// File: rtl/scroll_displayer_tick_prescaler.sv
// tick_prescaler: counts 0..FREQ-1 while en, pulses tick on wrap.
// clr forces the count to zero and suppresses tick.
module tick_prescaler #(
  parameter int FREQ = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(FREQ);
  localparam logic [CW-1:0] LAST = CW'(FREQ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scroll_displayer.sv
// scroll_displayer: scrolling hex window on seven-seg digits.
// SCROLL_DISPLAYER_BLINK_EN adds a blink of the held window.
module scroll_displayer
  import scroll_displayer_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 16,
  parameter int FREQ       = 25_000_000,
  parameter int LED_W      = 8
) (
  input logic clk,
  input logic rst,
  scroll_displayer_if.slave bus
);

  localparam int PW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int LIM = MSG_LEN - NUM_DIGITS;
  localparam int SEG = MSG_LEN / LED_W;
  localparam int VW  = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] P_LAST = PW'(MSG_LEN - 1);
  localparam logic [PW-1:0] P_LIM  = PW'(LIM);
  localparam logic [LED_W-1:0] LED_MSB =
    LED_W'(1) << (LED_W - 1);

  mode_e mode;
  logic  hold;
  logic  tick;
  logic  blank;
  logic  bup, bdn;

  logic [PW-1:0] pos_q, pos_d;
  dir_e          dir_q, dir_d;
  logic          step_q;

  logic [VW-1:0]                 vis;
  logic [NUM_DIGITS-1:0][6:0]    win;
  logic [NUM_DIGITS*7-1:0]       digits_q, digits_d;
  logic [LED_W-1:0]              led_q, led_d;

  assign mode = mode_e'(bus.mode);
  assign hold = (mode == MODE_HOLD);

  tick_prescaler #(
    .FREQ(FREQ)
  ) u_step (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .clr (hold),
    .tick(tick)
  );

`ifdef SCROLL_DISPLAYER_BLINK_EN
  logic blink_tick;
  logic blink_q;

  tick_prescaler #(
    .FREQ(FREQ)
  ) u_blink (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .clr (1'b0),
    .tick(blink_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= 1'b0;
    end else if (blink_tick) begin
      blink_q <= ~blink_q;
    end
  end

  assign blank = hold && blink_q;
`else
  assign blank = 1'b0;
`endif

  // Bounce: above range or at the top always heads down
  assign bup = (pos_q < P_LIM) &&
               ((dir_q == DIR_UP) || (pos_q == '0));
  assign bdn = !bup && (pos_q != '0);

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick) begin
      unique case (mode)
        MODE_LEFT: begin
          pos_d = (pos_q == P_LAST) ? '0 : pos_q + 1'b1;
        end
        MODE_RIGHT: begin
          pos_d = (pos_q == '0) ? P_LAST : pos_q - 1'b1;
        end
        MODE_BOUNCE: begin
          if (bup) begin
            pos_d = pos_q + 1'b1;
          end else if (bdn) begin
            pos_d = pos_q - 1'b1;
          end
          if (pos_d == P_LIM) begin
            dir_d = DIR_DOWN;
          end else if (pos_d == '0) begin
            dir_d = DIR_UP;
          end else begin
            dir_d = bup ? DIR_UP : DIR_DOWN;
          end
        end
        MODE_HOLD: ;
      endcase
    end
  end

  // Doubled message makes the wrap-around window a plain shift
  assign vis = VW'({bus.msg, bus.msg} >> (4 * pos_q));

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign win[k] = hex2seg(vis[4*(NUM_DIGITS-1-k) +: 4]);
  end

  assign digits_d = blank ? {NUM_DIGITS{SEG_BLANK}} : win;
  assign led_d    = LED_MSB >> (int'(pos_q) / SEG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q    <= '0;
      dir_q    <= DIR_UP;
      step_q   <= 1'b0;
      digits_q <= {NUM_DIGITS{SEG_BLANK}};
      led_q    <= '0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= tick;
      digits_q <= digits_d;
      led_q    <= led_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.led    = led_q;
  assign bus.step   = step_q;

endmodule

// File: tb/tb_scroll_displayer.sv
// Bench for scroll_displayer: small build, behavioural model
// compared every cycle plus hand-computed literal checks.
module tb_scroll_displayer;

  localparam int N   = 4;
  localparam int M   = 8;
  localparam int F   = 4;
  localparam int LW  = 4;
  localparam int LIM = M - N;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef struct {
    int cnt;
    int pos;
    bit up;
    int bcnt;
    bit blink;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;

  logic [6:0] segtab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  scroll_displayer_if #(
    .NUM_DIGITS(N), .MSG_LEN(M), .LED_W(LW)
  ) bus ();

  scroll_displayer #(
    .NUM_DIGITS(N), .MSG_LEN(M), .FREQ(F), .LED_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  mstate_t         ms = '{0, 0, 1'b1, 0, 1'b0};
  logic [N*7-1:0]  m_dig = '1;
  logic [LW-1:0]   m_led = '0;
  logic            m_step = 1'b0;

  function automatic logic [N*7-1:0] window(
    input int p, input logic [M*4-1:0] msg
  );
    logic [N*7-1:0] r;
    logic [3:0]     sym;
    int             s;
    r = '0;
    for (int k = 0; k < N; k++) begin
      s   = (p + N - 1 - k) % M;
      sym = msg[4*s +: 4];
      r[7*k +: 7] = segtab[sym];
    end
    return r;
  endfunction

  function automatic bit will_tick(
    input mstate_t s, input logic en, input logic [1:0] mode
  );
    return en && (mode != 2'b11) && (s.cnt == F - 1);
  endfunction

  function automatic mstate_t advance(
    input mstate_t s, input logic en, input logic [1:0] mode
  );
    mstate_t r;
    r = s;
    if (mode == 2'b11) r.cnt = 0;
    else if (en) r.cnt = (s.cnt + 1) % F;
    if (will_tick(s, en, mode)) begin
      case (mode)
        2'b00: r.pos = (s.pos + 1) % M;
        2'b01: r.pos = (s.pos + M - 1) % M;
        2'b10: begin
          if (s.pos > LIM) begin
            r.pos = s.pos - 1;
            r.up  = 1'b0;
          end else begin
            if (s.pos == LIM) r.up = 1'b0;
            else if (s.pos == 0) r.up = 1'b1;
            r.pos = r.up ? s.pos + 1 : s.pos - 1;
          end
          if (r.pos == LIM) r.up = 1'b0;
          else if (r.pos == 0) r.up = 1'b1;
        end
        default: ;
      endcase
    end
`ifdef SCROLL_DISPLAYER_BLINK_EN
    if (en) begin
      if (s.bcnt == F - 1) begin
        r.bcnt  = 0;
        r.blink = !s.blink;
      end else begin
        r.bcnt = s.bcnt + 1;
      end
    end
`endif
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms     <= '{0, 0, 1'b1, 0, 1'b0};
      m_dig  <= {N{BLANK}};
      m_led  <= '0;
      m_step <= 1'b0;
    end else begin
      m_dig  <= (bus.mode == 2'b11 && ms.blink) ? {N{BLANK}}
                : window(ms.pos, bus.msg);
      m_led  <= LW'(1) << (LW - 1 - ms.pos / (M / LW));
      m_step <= will_tick(ms, bus.en, bus.mode);
      ms     <= advance(ms, bus.en, bus.mode);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(
    input string name, input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("digits", 64'(bus.digits), 64'(m_dig));
      chk("led", 64'(bus.led), 64'(m_led));
      chk("step", 64'(bus.step), 64'(m_step));
    end
  end

  function automatic int segidx(input logic [6:0] x);
    for (int i = 0; i < 16; i++) begin
      if (segtab[i] == x) return i;
    end
    return -1;
  endfunction

  function automatic int leftpos();
    return segidx(bus.digits[N*7-1 -: 7]);
  endfunction

  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.step && cyc < 20);
  endtask

  task automatic do_reset(input logic [1:0] md);
    @(negedge clk);
    rst = 1'b0;
    bus.mode = md;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int cyc;
  int bseq [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
  int dseq [4] = '{5, 4, 3, 2};
  int lm;
  logic [N*7-1:0] held;

  initial begin
    bus.en   = 1'b1;
    bus.mode = 2'b00;
    bus.msg  = 32'h76543210;
    #3 rst = 1'b0;
    #4 checking = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_digits", 64'(bus.digits), 64'({N{BLANK}}));
    chk("rst_led", 64'(bus.led), 64'(4'b0000));
    rst = 1'b1;

    // first refresh: symbols 0,1,2,3 left to right
    @(negedge clk);
    chk("win0", 64'(bus.digits),
        64'({7'h40, 7'h79, 7'h24, 7'h30}));
    chk("led0", 64'(bus.led), 64'(4'b1000));

    wait_step(cyc);
    chk("first_gap", 64'(cyc), 64'(3));
    for (int i = 0; i < 7; i++) begin
      wait_step(cyc);
      chk("step_gap", 64'(cyc), 64'(4));
    end
    @(negedge clk);
    chk("wrap_pos", 64'(leftpos()), 64'(0));

    // right mode from reset
    do_reset(2'b01);
    wait_step(cyc);
    @(negedge clk);
    chk("right_win", 64'(bus.digits),
        64'({7'h78, 7'h40, 7'h79, 7'h24}));
    chk("right_led", 64'(bus.led), 64'(4'b0001));

    // bounce from reset
    do_reset(2'b10);
    for (int i = 0; i < 9; i++) begin
      wait_step(cyc);
      @(negedge clk);
      chk("bounce_pos", 64'(leftpos()), 64'(bseq[i]));
    end

    // left to 6, then bounce must come straight down
    do_reset(2'b00);
    for (int i = 0; i < 6; i++) wait_step(cyc);
    @(negedge clk);
    chk("left6", 64'(leftpos()), 64'(6));
    bus.mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      wait_step(cyc);
      @(negedge clk);
      chk("enter_bounce", 64'(leftpos()), 64'(dseq[i]));
    end

    // freeze with count at 2
    bus.mode = 2'b00;
    wait_step(cyc);
    @(negedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    lm = leftpos();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("frz_step", 64'(bus.step), 64'(0));
    end
    chk("frz_pos", 64'(leftpos()), 64'(lm));
    bus.en = 1'b1;
    wait_step(cyc);
    chk("resume_gap", 64'(cyc), 64'(2));

    // async reset while bouncing down
    do_reset(2'b10);
    for (int i = 0; i < 5; i++) wait_step(cyc);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_digits", 64'(bus.digits), 64'({N{BLANK}}));
    chk("arst_led", 64'(bus.led), 64'(4'b0000));
    chk("arst_step", 64'(bus.step), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_pos0", 64'(leftpos()), 64'(0));
    chk("arst_led0", 64'(bus.led), 64'(4'b1000));
    wait_step(cyc);
    @(negedge clk);
    chk("arst_dirup", 64'(leftpos()), 64'(1));

    // hold mode
    bus.mode = 2'b11;
    @(negedge clk);
    @(negedge clk);
    held = bus.digits;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("hold_step", 64'(bus.step), 64'(0));
`ifndef SCROLL_DISPLAYER_BLINK_EN
      chk("hold_static", 64'(bus.digits), 64'(held));
`endif
    end

    // randomized run against the model
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0)
        bus.mode = 2'($urandom_range(0, 3));
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0)
        bus.msg = $urandom;
    end

    @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/scroll_displayer.md
Name: scroll_displayer

Overview:
- Parametrised successor to the fixed 8-digit cycled displayer.
- Shows a NUM_DIGITS-wide window onto a MSG_LEN-symbol hex message on active-low seven-segment digits. The window advances once per FREQ clock cycles in one of four modes: left, right, bounce or hold.
- A one-hot LED bar shows window position.
- Sits between the board top level (switches, HEX, LEDR) and the 50 MHz clock domain.

Parameters:
- NUM_DIGITS, 8, number of seven-segment digits driven.
- MSG_LEN, 16, number of 4-bit symbols in the message; must be >= NUM_DIGITS.
- FREQ, 25_000_000, clk cycles per scroll step; must be >= 2.
- LED_W, 8, width of the position LED bar; MSG_LEN must be a multiple of LED_W.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous, active-low.
- en, input, 1, run enable; low freezes prescaler and position.
- mode, input, 2, 00 left, 01 right, 10 bounce, 11 hold.
- msg, input, MSG_LEN*4, symbol j = msg[4j+3:4j]; treated as quasi-static.
- digits, output, NUM_DIGITS*7, digit k = digits[7k+6:7k]; active-low segments g..a; k = NUM_DIGITS-1 is leftmost.
- led, output, LED_W, one-hot window position.
- step, output, 1, one-cycle pulse on each scroll tick.

Behaviour:
- **Reset (rst=0, async):**
  - prescaler cnt=0, pos=0, dir=up.
  - step=0, led=0.
  - digits all 7'h7F (blank).
  - First window refresh appears on the first clk edge after rst deasserts.
- **Prescaler:**
  - With en=1, cnt counts 0..FREQ-1 and wraps.
  - tick = en && cnt==FREQ-1.
  - With en=0, cnt holds.
  - In mode 11, cnt is cleared to 0 every cycle and tick never fires.
- **Position update on tick:**
  - Left: pos = (pos+1) mod MSG_LEN; MSG_LEN-1 wraps to 0.
  - Right: pos = (pos-1) mod MSG_LEN; 0 wraps to MSG_LEN-1.
  - Bounce, dir=up: increment until pos == MSG_LEN-NUM_DIGITS. The tick that reaches the limit sets dir=down.
  - Bounce, dir=down: decrement until pos == 0. The tick that reaches 0 sets dir=up.
  - Bounce with MSG_LEN == NUM_DIGITS: pos stays 0.
- **Mode change:**
  - Sampled every cycle; takes effect on the next tick; pos is retained.
  - Entering bounce with pos > MSG_LEN-NUM_DIGITS: dir is forced down and pos decrements on each tick until inside range.
  - Left and right modes do not alter dir.
- **Window mapping:** digit k shows symbol (pos + NUM_DIGITS-1-k) mod MSG_LEN, so the leftmost digit shows symbol pos.
- **Decode:**
  - Hex decode 0-F to active-low segments: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E.
- **Registered outputs:**
  - digits and led are registered every cycle from the current pos and msg.
  - Latency: pos updates on the tick edge; digits/led follow one clk later.
  - step is registered tick, aligned with the pos update.
- **LED bar:** led = one-hot, bit (LED_W-1 - pos/(MSG_LEN/LED_W)) set; pos 0 lights the MSB.
- **en low mid-step:** cnt, pos and dir all hold; resume from the same cnt value.
- **Reset mid-operation:** immediate return to reset values regardless of mode or cnt.

Optional Feature:
- Macro SCROLL_DISPLAYER_BLINK_EN.
- Defined: a blink flag toggles every FREQ cycles using a free-running prescaler that runs while en=1. In mode 11 only, digits are blanked (7'h7F) while the flag is 1; led is unaffected; the flag resets to 0.
- Undefined: mode 11 shows a static window; no extra state.

Decomposition:
- Package scroll_displayer_pkg holds:
  - mode encoding constants (MODE_LEFT, MODE_RIGHT, MODE_BOUNCE, MODE_HOLD);
  - SEG_BLANK = 7'h7F;
  - the hex-to-segment decode function.
- One natural sub-module: tick_prescaler (FREQ parameter; clk, rst, en, clr in; tick out), reused for the blink prescaler.

Test Plan:
- Small build NUM_DIGITS=4, MSG_LEN=8, FREQ=4, LED_W=4, msg=32'h76543210, en=1, mode=00:
  - After reset: digits blank, led=0.
  - One cycle later: digits show 0,1,2,3 left to right, led=4'b1000.
  - step pulses every 4 cycles; after 8 steps pos wraps to 0.
- Mode=01 from reset: first step gives pos=7, leftmost=7, window 7,0,1,2, led=4'b0001.
- Mode=10: pos sequence 0,1,2,3,4,3,2,1,0,1 across 9 steps.
  - Set pos=6 via left mode, then switch to bounce: pos goes 5,4,… with no overshoot.
- en=0 for 10 cycles mid-count (cnt=2): no step; after en=1, next step arrives 2 cycles later; pos unchanged during freeze.
- Assert rst low asynchronously mid-step in bounce/down: outputs blank and led=0 without a clk edge; after release, restarts at pos=0, dir=up.
- With SCROLL_DISPLAYER_BLINK_EN, mode=11: digits alternate window/blank every 4 cycles and step stays 0; without the macro, the window is static.
